// File: rtl/adc081c021_i2c_responder.sv
// ---------------------------------------------------------------------------
// adc081c021_i2c_responder
//
// Purpose:
//   I2C target that stands in for an ADC081C021 on the conversion-result read
//   path. An address+R transfer is answered with the two-byte result word built
//   from the parallel 'sample' input. Writes are ACKed and discarded, so a
//   master that writes the pointer register first still works. SDA is
//   open-drain (sda_oe pulls low). SCL is only observed, never stretched.
//
// Ports:
//   sclk         in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   scl_in       in   SCL pin level (asynchronous)
//   sda_in       in   SDA pin level (asynchronous)
//   sda_oe       out  1 = pull SDA low, 0 = release
//   sample [7:0] in   conversion value to report
//   sample_taken out  one-cycle pulse when 'sample' is latched for a read
//   read_done    out  one-cycle pulse when the master NACKs a transmitted byte
//   busy         out  high from an addressed START until STOP or NACK
// ---------------------------------------------------------------------------
module adc081c021_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h54,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] sample,
    output logic       sample_taken,
    output logic       read_done,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_TX       = 3'd3;
    localparam logic [2:0] ST_TX_ACK   = 3'd4;
    localparam logic [2:0] ST_RX       = 3'd5;
    localparam logic [2:0] ST_RX_ACK   = 3'd6;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       rw_q, rw_d;
    // Second half of a two-fall ACK slot (or "next byte already loaded" in TX_ACK).
    logic       phase_q, phase_d;
    // 0 = byte0 goes out next, 1 = byte1 goes out next.
    logic       byte_sel_q, byte_sel_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       sample_taken_q, sample_taken_d;
    logic       read_done_q, read_done_d;

    logic scl_s, sda_s;
    logic start_det, stop_det, scl_rise, scl_fall;
    logic [7:0] byte0, byte1;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP require SCL high on both sides of the SDA transition so that
    // an SDA change racing an SCL edge is never mistaken for a bus condition.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;

    // Result word layout: D[11:4] = hold, alert flag and low nibble zero.
    assign byte0 = {4'b0000, hold_q[7:4]};
    assign byte1 = {hold_q[3:0], 4'b0000};

    // Input synchronizers and the one-deep history used for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Protocol FSM. Data is sampled on SCL rise; sda_oe is only recomputed on
    // an SCL fall, so the registered output moves one cycle after the fall.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        hold_d         = hold_q;
        rw_d           = rw_q;
        phase_d        = phase_q;
        byte_sel_d     = byte_sel_q;
        sda_oe_d       = sda_oe_q;
        busy_d         = busy_q;
        sample_taken_d = 1'b0;
        read_done_d    = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            // shift_q[6:0] already holds the seven address bits; sda_s is R/W.
                            if (shift_q[6:0] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                phase_d = 1'b0;
                                rw_d    = sda_s;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            phase_d  = 1'b1;
                        end else if (rw_q) begin
                            hold_d         = sample;
                            shift_d        = {4'b0000, sample[7:4]};
                            byte_sel_d     = 1'b1;
                            sample_taken_d = 1'b1;
                            // byte0 always starts with a 0, so the first data bit pulls low.
                            sda_oe_d       = 1'b1;
                            bit_cnt_d      = 3'd0;
                            phase_d        = 1'b0;
                            state_d        = ST_TX;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            phase_d   = 1'b0;
                            state_d   = ST_RX;
                        end
                    end
                end

                ST_TX: begin
                    // bit_cnt counts bits whose SCL high phase has completed.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            phase_d   = 1'b0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (!phase_q && scl_rise) begin
                        if (sda_s) begin
                            read_done_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = ST_IDLE;
                        end else begin
                            shift_d    = byte_sel_q ? byte1 : byte0;
                            byte_sel_d = ~byte_sel_q;
                            phase_d    = 1'b1;
                        end
                    end else if (phase_q && scl_fall) begin
                        sda_oe_d  = ~shift_q[7];
                        bit_cnt_d = 3'd0;
                        phase_d   = 1'b0;
                        state_d   = ST_TX;
                    end
                end

                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            phase_d   = 1'b0;
                            state_d   = ST_RX_ACK;
                        end
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RX;
                        end
                    end
                end

                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // Synchronizers reset to the idle-high bus level so reset release cannot
    // fabricate a START or STOP.
    always_ff @(posedge sclk) begin
        if (rst) begin
            scl_sync_q     <= '1;
            sda_sync_q     <= '1;
            scl_prev_q     <= 1'b1;
            sda_prev_q     <= 1'b1;
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            hold_q         <= 8'h00;
            rw_q           <= 1'b0;
            phase_q        <= 1'b0;
            byte_sel_q     <= 1'b0;
            sda_oe_q       <= 1'b0;
            busy_q         <= 1'b0;
            sample_taken_q <= 1'b0;
            read_done_q    <= 1'b0;
        end else begin
            scl_sync_q     <= scl_sync_d;
            sda_sync_q     <= sda_sync_d;
            scl_prev_q     <= scl_prev_d;
            sda_prev_q     <= sda_prev_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            hold_q         <= hold_d;
            rw_q           <= rw_d;
            phase_q        <= phase_d;
            byte_sel_q     <= byte_sel_d;
            sda_oe_q       <= sda_oe_d;
            busy_q         <= busy_d;
            sample_taken_q <= sample_taken_d;
            read_done_q    <= read_done_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign sample_taken = sample_taken_q;
    assign read_done    = read_done_q;

endmodule
